// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES types and constants for the key schedule and the round datapath.
//   word_t       : one 32-bit column of the AES state / key
//   block_t      : one 128-bit block (state or round key)
//   round_idx_t  : round index 0..10
//   ks_state_e   : key-schedule controller state (IDLE / ACTIVE)
//   NR           : number of rounds for AES-128
//   RCON         : round constants, indexed 1..10
//   SBOX         : FIPS-197 forward S-box, indexed by input byte
// Helpers: rot_word, rcon_lookup, sbox_lookup.
// -----------------------------------------------------------------------------
package aes_pkg;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;
  typedef logic [3:0]   round_idx_t;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } ks_state_e;

  localparam int NR = 10;

  localparam logic [1:10][7:0] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Rotate a word left by one byte: {a0,a1,a2,a3} -> {a1,a2,a3,a0}.
  function automatic word_t rot_word(word_t w);
    return {w[23:0], w[31:24]};
  endfunction

  // Round constant for round r; rounds outside 1..10 contribute nothing.
  function automatic logic [7:0] rcon_lookup(round_idx_t r);
    logic [7:0] rc;
    if ((r >= 4'd1) && (r <= 4'd10)) begin
      rc = RCON[r];
    end else begin
      rc = 8'h00;
    end
    return rc;
  endfunction

  function automatic logic [7:0] sbox_lookup(logic [7:0] b);
    return SBOX[b];
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// -----------------------------------------------------------------------------
// aes_sbox
// Combinational AES forward S-box, one byte wide. Used four times for SubWord
// in the key schedule and shared with the round datapath.
//   in_byte  : input byte
//   out_byte : substituted byte
// -----------------------------------------------------------------------------
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  // Table lookup; synthesises to a 256-entry ROM / logic cone.
  always_comb begin
    out_byte = sbox_lookup(in_byte);
  end

endmodule

// File: rtl/aes_key_expand.sv
// -----------------------------------------------------------------------------
// aes_key_expand
// Iterative AES-128 key schedule. start loads the cipher key as round key 0;
// each accepted advance produces the next round key up to round 10, computed
// on the fly from the previous round key (no 11-entry key store).
//   clk       : rising-edge clock
//   reset     : synchronous, active-high reset
//   start     : load key and begin a schedule (accepted only when idle)
//   key       : cipher key, sampled when start is accepted
//   advance   : consumer has used round_key; step to the next round
//   round_key : current round key (registered)
//   round_num : index of round_key, 0..10 (registered)
//   key_valid : round_key/round_num are valid
//   busy      : schedule in progress
//   done      : one-cycle pulse after the round-10 key is consumed
// Parameters: NR (must be 10), AUTO_ADVANCE (1 = step every active cycle).
// -----------------------------------------------------------------------------
module aes_key_expand #(
  parameter int NR           = 10,
  parameter bit AUTO_ADVANCE = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] key,
  input  logic         advance,
  output logic [127:0] round_key,
  output logic [3:0]   round_num,
  output logic         key_valid,
  output logic         busy,
  output logic         done
);

  import aes_pkg::*;

  localparam round_idx_t LAST_ROUND = round_idx_t'(aes_pkg::NR);

  if (NR != aes_pkg::NR) begin : g_nr_check
    $error("aes_key_expand: only NR=10 (AES-128) is supported");
  end

  ks_state_e  state_q,     state_d;
  block_t     round_key_q, round_key_d;
  round_idx_t round_num_q, round_num_d;
  logic       key_valid_q, key_valid_d;
  logic       busy_q,      busy_d;
  logic       done_q,      done_d;

  word_t      w0_s, w1_s, w2_s, w3_s;
  word_t      w4_s, w5_s, w6_s, w7_s;
  word_t      rot_s, sub_s, temp_s;
  round_idx_t rcon_idx_s;
  logic [7:0] rcon_s;
  block_t     next_key_s;
  logic       advance_s;

  // Expansion datapath: the only logic between the round_key flops and
  // round_key_d is RotWord (wiring), four S-boxes and the XOR chain.
  assign w0_s  = round_key_q[127:96];
  assign w1_s  = round_key_q[95:64];
  assign w2_s  = round_key_q[63:32];
  assign w3_s  = round_key_q[31:0];
  assign rot_s = rot_word(w3_s);

  for (genvar i = 0; i < 4; i++) begin : g_subword
    aes_sbox u_sbox (
      .in_byte  (rot_s[8*i +: 8]),
      .out_byte (sub_s[8*i +: 8])
    );
  end

  // The key being produced belongs to round_num+1, so that is the rcon index.
  assign rcon_idx_s = round_num_q + 4'd1;
  assign rcon_s     = rcon_lookup(rcon_idx_s);
  assign temp_s     = sub_s ^ {rcon_s, 24'h000000};

  assign w4_s       = w0_s ^ temp_s;
  assign w5_s       = w4_s ^ w1_s;
  assign w6_s       = w5_s ^ w2_s;
  assign w7_s       = w6_s ^ w3_s;
  assign next_key_s = {w4_s, w5_s, w6_s, w7_s};

  assign advance_s  = AUTO_ADVANCE ? 1'b1 : advance;

  // Next-state and next-output computation for the schedule controller.
  always_comb begin
    state_d     = state_q;
    round_key_d = round_key_q;
    round_num_d = round_num_q;
    key_valid_d = key_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        // advance is deliberately not looked at here, even alongside start.
        if (start) begin
          round_key_d = key;
          round_num_d = 4'd0;
          key_valid_d = 1'b1;
          busy_d      = 1'b1;
          state_d     = ACTIVE;
        end else begin
          state_d     = IDLE;
        end
      end
      ACTIVE: begin
        // start is ignored while a schedule is running.
        if (advance_s) begin
          if (round_num_q < LAST_ROUND) begin
            round_key_d = next_key_s;
            round_num_d = round_num_q + 4'd1;
          end else begin
            // Last key consumed: round_key/round_num keep their final values.
            key_valid_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            state_d     = IDLE;
          end
        end else begin
          state_d     = ACTIVE;
        end
      end
      default: begin
        state_d     = IDLE;
        key_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      round_key_q <= 128'h0;
      round_num_q <= 4'd0;
      key_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      round_key_q <= round_key_d;
      round_num_q <= round_num_d;
      key_valid_q <= key_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign round_key = round_key_q;
  assign round_num = round_num_q;
  assign key_valid = key_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
